alu_exec: RTL and testbench
===========================

# alu_exec

Execute-stage ALU for the MIPS pipeline; the consumer of the 5-bit `alucontrol` code produced by decode. Single-cycle operations return a registered result one cycle after acceptance. MULT/MULTU/DIV/DIVU run on an iterative 32-cycle datapath that writes the HI/LO registers and stalls the pipeline through `in_ready`. MFHI/MFLO/MTHI/MTLO are served from the same HI/LO pair.

## Interface
- `WIDTH`, default 32: operand and result width; the block is verified only at 32.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `flush  in  1`: aborts an in-flight multiply/divide and drops any pending result.
- `in_valid  in  1`: operation presented.
- `in_ready  out  1`: block can accept; high only in IDLE; combinational from state.
- `alucontrol  in  5`: operation code.
- `a  in  WIDTH`: rs operand.
- `b  in  WIDTH`: rt operand, or the immediate after extension.
- `out_valid  out  1`: one-cycle pulse, result valid.
- `result  out  WIDTH`: GPR result.
- `out_wb  out  1`: result targets a GPR. Low for MULT*/DIV*/MTHI/MTLO.
- `zero  out  1`: result == 0.
- `overflow  out  1`: signed overflow; ADD and SUB only.
- `illegal  out  1`: `alucontrol` is not a defined code.

## Operation
Control codes (5-bit binary):
- AND 00000, OR 00001, ADD 00010, XOR 00100, NOR 00101, SUB 00110, SLT 00111, LUI 01000.
- MULT 10000, MULTU 10001, DIV 10010, DIVU 10011.
- MFHI 10100, MFLO 10101, MTHI 10110, MTLO 10111.

Single-cycle operations:
- Arithmetic is modulo 2^32.
- SLT is a signed compare; result is 0 or 1.
- LUI returns `b<<16`.
- MTHI/MTLO write `a` to HI/LO.
- An undefined code gives result 0, `illegal`=1, `out_wb`=0.

Multi-cycle datapath:
- Shift-add multiply and restoring divide, both on operand magnitudes; the signed variants apply a sign fix at the end.
- Product: HI:LO = 64-bit product.
- Divide: LO = quotient, truncated toward zero. HI = remainder, carrying the dividend's sign.
- Divide by zero is defined: the quotient magnitude is all-ones and the remainder is the dividend, before the sign fix. For DIVU x/0 this gives LO=0xFFFFFFFF, HI=x.

State machine:
- IDLE, with handshake on MULT*: go to MUL_RUN, count=0, latch magnitudes and sign flags.
- IDLE, with handshake on DIV*: go to DIV_RUN, same latching.
- MUL_RUN/DIV_RUN: one iteration per cycle. Move to FIX when count reaches 31.
- FIX: apply sign correction, write HI/LO, pulse `out_valid` (`out_wb`=0, result=0), return to IDLE.
- `flush` in any RUN state or FIX: return to IDLE. HI/LO are unchanged and no `out_valid` is produced.
- `flush` together with a single-cycle handshake: the operation is dropped and `out_valid` stays 0. MTHI/MTLO do not write.
- `in_valid` without `in_ready` is ignored; the upstream stage holds its operands.

## Timing
- Reset values: state=IDLE, HI=LO=0. Outputs: `in_ready`=1; `out_valid`, `result`, `out_wb`, `zero`, `overflow`, `illegal` all 0.
- Single-cycle operation: handshake at edge E0 gives `out_valid` for the one cycle after E0. Back-to-back issue runs at one operation per cycle.
- MFHI/MFLO issued the cycle after an MTHI/MTLO return the newly written value, because the write lands at E0.
- Multi-cycle operation: handshake at E0; iterations at E1–E32; FIX at E33. `out_valid` is high for the cycle after E33 and `in_ready` returns at the same point, giving a total latency of 33 cycles.
- Reset asserted mid-operation: immediate return to reset values, with no partial HI/LO write.

## Structure
- All control codes go in the shared defines header, alongside the decode-side definitions.
- Sub-module `muldiv_iter` holds the iteration counter, the 64-bit accumulator/remainder, and the sign fix, with `start`/`op`/`done`/`abort` signals.
- `alu_exec` owns the FSM, HI/LO, the single-cycle datapath, and the output registers.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → next cycle result=0x80000000, overflow=1, out_wb=1. SUB 5−5 → zero=1.
- SLT a=0xFFFFFFFF, b=1 → result=1. LUI b=0x1234 → result=0x12340000. Code 01111 → illegal=1, result=0.
- MULT a=0xFFFFFFFE, b=3 → in_ready low for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFLO next → 0xFFFFFFFA.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7.
- DIVU started, flush on cycle 10 → in_ready=1 next cycle, no out_valid, HI/LO keep prior values.
- rst asserted mid-MULT → all outputs 0 immediately, HI=LO=0, in_ready=1. MTHI 0x55 then MFHI back-to-back → 0x55.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared ALU control codes and execute-stage FSM states for alu_exec.
// Decode drives alucontrol with these values; keep the two sides in step.
package alu_exec_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_XOR   = 5'b00100,
    OP_NOR   = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_SLT   = 5'b00111,
    OP_LUI   = 5'b01000,
    OP_MULT  = 5'b10000,
    OP_MULTU = 5'b10001,
    OP_DIV   = 5'b10010,
    OP_DIVU  = 5'b10011,
    OP_MFHI  = 5'b10100,
    OP_MFLO  = 5'b10101,
    OP_MTHI  = 5'b10110,
    OP_MTLO  = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_DIV_RUN,
    ST_FIX
  } state_e;

  // MULT/MULTU/DIV/DIVU share the 100xx prefix; bit1 = divide, bit0 = unsigned.
  function automatic logic is_muldiv(input logic [4:0] code);
    return code[4:2] == 3'b100;
  endfunction

endpackage

// File: rtl/alu_exec_muldiv_iter.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes, one step per cycle.
// WIDTH iterations after start; done flags the last one; abort stops it with no side effects.
module muldiv_iter
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               run_q, run_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] prod_fix;

  assign sign_a   = ~op[0] & a[WIDTH-1];
  assign sign_b   = ~op[0] & b[WIDTH-1];
  assign mag_a_in = sign_a ? -a : a;
  assign mag_b_in = sign_b ? -b : b;

  // acc = {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, mag_b_q} & {(WIDTH+1){acc_q[0]}});
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, mag_b_q};
  assign rem_new = rem_ge ? rem_sh[WIDTH-1:0] - mag_b_q : rem_sh[WIDTH-1:0];

  always_comb begin
    run_d     = run_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_b_d   = mag_b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    if (start) begin
      run_d     = 1'b1;
      cnt_d     = '0;
      acc_d     = {{WIDTH{1'b0}}, mag_a_in};
      mag_b_d   = mag_b_in;
      is_div_d  = op[1];
      neg_d     = sign_a ^ sign_b;
      neg_rem_d = sign_a;
    end else if (abort) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) run_d = 1'b0;
      acc_d = is_div_q ? {rem_new, acc_q[WIDTH-2:0], rem_ge} : {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_b_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_b_q   <= mag_b_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Remainder takes the dividend's sign, quotient/product the XOR of both signs.
  assign done     = run_q & (cnt_q == LAST);
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign hi = is_div_q ? (neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH])
                       : prod_fix[2*WIDTH-1:WIDTH];
  assign lo = is_div_q ? (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])
                       : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops return one cycle after accept; MULT*/DIV* take 33 cycles.
// in_ready is low for the whole multiply/divide; flush drops any in-flight or same-cycle operation.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_wb,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_wb_q, out_wb_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic             accept, md_start, md_abort, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] sum, diff, sc_result;
  logic             sc_wb, sc_ovf, sc_ill;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign md_start = accept & is_muldiv(alucontrol);
  assign md_abort = flush & (state_q != ST_IDLE);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (alucontrol[1:0]),
    .abort (md_abort),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    sc_result = '0;
    sc_wb     = 1'b1;
    sc_ovf    = 1'b0;
    sc_ill    = 1'b0;
    case (alucontrol)
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_NOR: sc_result = ~(a | b);
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_LUI:  sc_result = b << 16;
      OP_MFHI: sc_result = hi_q;
      OP_MFLO: sc_result = lo_q;
      OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: sc_wb = 1'b0;
      default: begin
        sc_wb  = 1'b0;
        sc_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    result_d    = '0;
    out_wb_d    = 1'b0;
    overflow_d  = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = alucontrol[1] ? ST_DIV_RUN : ST_MUL_RUN;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = sc_result;
          out_wb_d    = sc_wb;
          overflow_d  = sc_ovf;
          illegal_d   = sc_ill;
          if (alucontrol == OP_MTHI) hi_d = a;
          if (alucontrol == OP_MTLO) lo_d = a;
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (flush)        state_d = ST_IDLE;
        else if (md_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d        = md_hi;
          lo_d        = md_lo;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = out_valid_d && (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_wb_q    <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_wb_q    <= out_wb_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_wb    = out_wb_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors push expected results, a negedge monitor pops them.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  alucontrol = 5'b0;
  logic [31:0] a = 32'b0;
  logic [31:0] b = 32'b0;
  logic        in_ready, out_valid, out_wb, zero, overflow, illegal;
  logic [31:0] result;

  alu_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .result     (result),
    .out_wb     (out_wb),
    .zero       (zero),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        wb;
    logic        ovf;
    logic        ill;
    logic        chk;
    logic [15:0] tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        mon_ok;
  int          total = 0;
  int          passed = 0;
  logic [15:0] tag_n = 16'd0;
  int          lat;

  task automatic expect_out(input logic [31:0] r, input logic wb, input logic ovf,
                            input logic ill, input logic chk);
    exp_t e;
    e.res = r; e.wb = wb; e.ovf = ovf; e.ill = ill; e.chk = chk; e.tag = tag_n;
    tag_n = tag_n + 16'd1;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic fl);
    in_valid = 1'b1; alucontrol = op; a = av; b = bv; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic sc(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] r, input logic wb, input logic ovf, input logic ill,
                    input logic chk);
    expect_out(r, wb, ovf, ill, chk);
    drive(op, av, bv, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Multi-cycle op: its FIX pulse carries result 0 with no GPR write.
  task automatic md(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    int n;
    expect_out(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(op, av, bv, 1'b0);
    wait_ready(n);
    total++;
    if (n == 33) passed++;
    else $display("FAIL md_busy_cycles op=%b: in_ready low for %0d cycles, want 33", op, n);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_out_valid: result=%h wb=%b with nothing pending", result, out_wb);
      end else begin
        mon_e  = sb_q.pop_front();
        mon_ok = (out_wb == mon_e.wb) && (overflow == mon_e.ovf) && (illegal == mon_e.ill) &&
                 (!mon_e.chk || ((result == mon_e.res) && (zero == (mon_e.res == 32'h0))));
        if (mon_ok) passed++;
        else $display("FAIL txn%0d: got result=%h wb=%b zero=%b ovf=%b ill=%b, want result=%h wb=%b zero=%b ovf=%b ill=%b",
                      mon_e.tag, result, out_wb, zero, overflow, illegal,
                      mon_e.res, mon_e.wb, (mon_e.res == 32'h0), mon_e.ovf, mon_e.ill);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passed, total);
    $fatal(1);
  end

  initial begin
    #1;
    total++;
    if (in_ready && !out_valid && result == 32'h0 && !out_wb && !zero && !overflow && !illegal)
      passed++;
    else $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h wb=%b zero=%b ovf=%b ill=%b, want 1 and all 0",
                  in_ready, out_valid, result, out_wb, zero, overflow, illegal);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle ops, issued back-to-back.
    sc(OP_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 1, 0, 1);
    sc(OP_SUB, 32'h5,        32'h5,        32'h0,        1, 0, 0, 1);
    sc(OP_SLT, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, 0, 1);
    sc(OP_SLT, 32'h1,        32'hFFFFFFFF, 32'h0,        1, 0, 0, 1);
    sc(OP_LUI, 32'hDEADBEEF, 32'h1234,     32'h12340000, 1, 0, 0, 1);
    sc(5'b01111, 32'h1,      32'h2,        32'h0,        0, 0, 1, 1);
    sc(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0, 0, 1);
    sc(OP_OR,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1, 0, 0, 1);
    sc(OP_XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1, 0, 0, 1);
    sc(OP_NOR, 32'h0,        32'h0,        32'hFFFFFFFF, 1, 0, 0, 1);
    sc(OP_SUB, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 1, 0, 1);
    sc(OP_ADD, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 1);
    sc(OP_ADD, 32'h80000000, 32'h80000000, 32'h0,        1, 1, 0, 1);
    sc(5'b11000, 32'h9,      32'h9,        32'h0,        0, 0, 1, 1);

    // Multiply / divide, read back through MFHI/MFLO.
    md(OP_MULT, 32'hFFFFFFFE, 32'h3);
    sc(OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1);
    sc(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFA, 1, 0, 0, 1);
    md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    sc(OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFE, 1, 0, 0, 1);
    sc(OP_MFLO, 32'h0, 32'h0, 32'h00000001, 1, 0, 0, 1);
    md(OP_DIV, 32'hFFFFFFF9, 32'h2);
    sc(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFD, 1, 0, 0, 1);
    sc(OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1);
    md(OP_DIVU, 32'h7, 32'h0);
    sc(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1);
    sc(OP_MFHI, 32'h0, 32'h0, 32'h00000007, 1, 0, 0, 1);

    // Flush mid-divide: back to idle next cycle, HI/LO untouched, no result.
    drive(OP_DIVU, 32'd100, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (in_ready) passed++;
    else $display("FAIL flush_in_ready: in_ready=%b, want 1", in_ready);
    repeat (40) @(posedge clk);
    #1;
    sc(OP_MFHI, 32'h0, 32'h0, 32'h00000007, 1, 0, 0, 1);
    sc(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1);

    // Flush alongside a single-cycle handshake: MTHI is dropped.
    drive(OP_MTHI, 32'hAA, 32'h0, 1'b1);
    sc(OP_MFHI, 32'h0, 32'h0, 32'h00000007, 1, 0, 0, 1);

    // Reset in the middle of a multiply.
    drive(OP_MULT, 32'h1234, 32'h5678, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (in_ready && !out_valid && result == 32'h0 && !out_wb && !zero && !overflow && !illegal)
      passed++;
    else $display("FAIL mid_op_reset: in_ready=%b out_valid=%b result=%h wb=%b zero=%b ovf=%b ill=%b, want 1 and all 0",
                  in_ready, out_valid, result, out_wb, zero, overflow, illegal);
    @(negedge clk) rst = 1'b0;
    sc(OP_MFHI, 32'h0,  32'h0, 32'h0,  1, 0, 0, 1);
    sc(OP_MFLO, 32'h0,  32'h0, 32'h0,  1, 0, 0, 1);
    sc(OP_MTHI, 32'h55, 32'h0, 32'h0,  0, 0, 0, 0);
    sc(OP_MFHI, 32'h0,  32'h0, 32'h55, 1, 0, 0, 1);
    sc(OP_MTLO, 32'h66, 32'h0, 32'h0,  0, 0, 0, 0);
    sc(OP_MFLO, 32'h0,  32'h0, 32'h66, 1, 0, 0, 1);

    repeat (5) @(posedge clk);
    #1;
    total++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL results_drained: %0d results never appeared, want 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
